// File: rtl/stack_if.sv
// Command/status bus between a requester and stack_ctrl, plus the stack
// datapath controls and the two stack read ports.
interface stack_if;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_imm;
  logic        cmd_ready;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [2:0]  depth;
  logic        load;
  logic        push;
  logic        pop;
  logic [15:0] d;
  logic [15:0] qtop;
  logic [15:0] qnext;

  // The requester also owns the stack storage, so it supplies qtop/qnext.
  modport master (
    output cmd_valid, cmd_op, cmd_imm, qtop, qnext,
    input  cmd_ready, done, err, err_code, depth, load, push, pop, d
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_imm, qtop, qnext,
    output cmd_ready, done, err, err_code, depth, load, push, pop, d
  );
endinterface

// File: rtl/stack_ctrl.sv
// Sequencer for a 6-entry external stack: decodes one command at a time,
// checks depth, and drives registered load/push/pop/d controls.
module stack_ctrl (
  input  logic   clk,
  input  logic   rst_n,
  stack_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, SW3} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_ADD, OP_SUB, OP_DUP, OP_SWAP, OP_DROP, OP_CLR
  } op_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_UDF} err_t;

  localparam logic [2:0] MAX_DEPTH = 3'd6;

  state_t      state_q, state_nx;
  op_t         op_q, op_nx;
  logic [15:0] imm_q, imm_nx;
  logic [15:0] res_q, res_nx;
  logic [15:0] t0_q, t0_nx;
  logic [15:0] t1_q, t1_nx;
  logic [2:0]  depth_q, depth_nx;
  logic        err_q, err_nx;
  err_t        code_q, code_nx;
  logic        done_q, done_nx;
  logic        load_q, load_nx;
  logic        push_q, push_nx;
  logic        pop_q, pop_nx;
  logic [15:0] d_q, d_nx;

  // NOTE: reset is synchronous, so it sits inside the clocked block and is
  // only seen on a rising edge; a mid-command reset simply discards state.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= OP_NOP;
      imm_q   <= '0;
      res_q   <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      d_q     <= '0;
    end else begin
      op_q    <= op_nx;
      imm_q   <= imm_nx;
      res_q   <= res_nx;
      t0_q    <= t0_nx;
      t1_q    <= t1_nx;
      depth_q <= depth_nx;
      err_q   <= err_nx;
      code_q  <= code_nx;
      done_q  <= done_nx;
      load_q  <= load_nx;
      push_q  <= push_nx;
      pop_q   <= pop_nx;
      d_q     <= d_nx;
    end
  end

  // NOTE: every target gets a default before the case so no path can leave
  // one unassigned and infer a latch; pulses default low, data holds.
  always_comb begin
    state_nx = state_q;
    op_nx    = op_q;
    imm_nx   = imm_q;
    res_nx   = res_q;
    t0_nx    = t0_q;
    t1_nx    = t1_q;
    depth_nx = depth_q;
    err_nx   = err_q;
    code_nx  = code_q;
    done_nx  = 1'b0;
    load_nx  = 1'b0;
    push_nx  = 1'b0;
    pop_nx   = 1'b0;
    d_nx     = d_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_nx    = op_t'(bus.cmd_op);
          imm_nx   = bus.cmd_imm;
          state_nx = EXEC;
        end
      end

      EXEC: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
        unique case (op_q)
          OP_NOP: ;
          OP_PUSH, OP_DUP: begin
            if (depth_q == MAX_DEPTH) begin
              err_nx  = 1'b1;
              code_nx = ERR_OVF;
            end else begin
              push_nx  = 1'b1;
              d_nx     = (op_q == OP_PUSH) ? imm_q : bus.qtop;
              depth_nx = depth_q + 3'd1;
            end
          end
          OP_DROP: begin
            if (depth_q == 3'd0) begin
              err_nx  = 1'b1;
              code_nx = ERR_UDF;
            end else begin
              pop_nx   = 1'b1;
              depth_nx = depth_q - 3'd1;
            end
          end
          OP_ADD, OP_SUB, OP_SWAP: begin
            if (depth_q < 3'd2) begin
              err_nx  = 1'b1;
              code_nx = ERR_UDF;
            end else begin
              // Two-entry ops pop now and write back from latched operands.
              res_nx   = (op_q == OP_ADD) ? bus.qnext + bus.qtop
                                          : bus.qnext - bus.qtop;
              t0_nx    = bus.qtop;
              t1_nx    = bus.qnext;
              pop_nx   = 1'b1;
              done_nx  = 1'b0;
              state_nx = WB;
            end
          end
          OP_CLR: begin
            depth_nx = '0;
            err_nx   = 1'b0;
            code_nx  = ERR_NONE;
          end
          default: ;
        endcase
      end

      WB: begin
        load_nx = 1'b1;
        if (op_q == OP_SWAP) begin
          d_nx     = t0_q;
          state_nx = SW3;
        end else begin
          d_nx     = res_q;
          depth_nx = depth_q - 3'd1;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end

      SW3: begin
        push_nx  = 1'b1;
        d_nx     = t1_q;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  assign bus.depth     = depth_q;
  assign bus.load      = load_q;
  assign bus.push      = push_q;
  assign bus.pop       = pop_q;
  assign bus.d         = d_q;

endmodule
